// File: rtl/ecp5pll_phase_pkg.sv
// Shared types and helpers for the ECP5 PLL dynamic phase-shift sequencer.
package ecp5pll_phase_pkg;

  localparam int POS_W = 8;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // One step of phase position; 9-bit intermediate so POS_MOD=256 wraps cleanly.
  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] p,
                                                input logic dir, input int modv);
    logic [POS_W:0] t;
    if (!dir) begin
      t = {1'b0, p} + 9'd1;
      if (t >= 9'(modv)) t = '0;
    end else begin
      t = (p == '0) ? 9'(modv - 1) : ({1'b0, p} - 9'd1);
    end
    return t[POS_W-1:0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
  input  logic clk_i,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequences PHASESTEP/PHASELOADREG pulses for the ECP5 PLL wrapper and tracks
// the accumulated phase position of each output.
module ecp5pll_phase_ctrl
  import ecp5pll_phase_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int POS_MOD   = 64
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        pll_locked_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic        req_dir,
  input  logic [7:0]  req_steps,
  input  logic        req_load,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        locked_o,
  output logic [31:0] pos_o,
  output logic [1:0]  phasesel,
  output logic        phasedir,
  output logic        phasestep,
  output logic        phaseloadreg
);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             rem_q, rem_d;
  logic [1:0]             sel_q, sel_d;
  logic                   dir_q, dir_d, load_q, load_d;
  logic                   err_q, err_d;
  logic [3:0][POS_W-1:0]  pos_q, pos_d;
  logic                   lock_lost;

  sync_2ff u_lock_sync (
    .clk_i (clk_i),
    .reset (reset),
    .d_i   (pll_locked_i),
    .q_o   (locked_o)
  );

  assign lock_lost = !locked_o && (state_q != ST_IDLE) && (state_q != ST_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    load_d  = load_q;
    pos_d   = pos_q;
    err_d   = 1'b0;
    // Abort wins even on the last pulse cycle, so a truncated pulse is never counted.
    if (lock_lost) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid && req_ready) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          rem_d   = req_steps;
          load_d  = req_load;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
        ST_SETUP: if (cnt_q == 4'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = (rem_q == '0 && !load_q) ? ST_DONE : ST_PULSE;
        end else cnt_d = cnt_q + 4'd1;
        ST_PULSE: if (cnt_q == 4'(PULSE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_GAP;
          if (load_q) pos_d[sel_q] = '0;
          else begin
            pos_d[sel_q] = pos_step(pos_q[sel_q], dir_q, POS_MOD);
            rem_d        = rem_q - 8'd1;
          end
        end else cnt_d = cnt_q + 4'd1;
        ST_GAP: if (cnt_q == 4'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = (rem_q != '0 && !load_q) ? ST_PULSE : ST_DONE;
        end else cnt_d = cnt_q + 4'd1;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      load_q  <= load_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE) && locked_o;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign err          = err_q;
  assign pos_o        = pos_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = (state_q == ST_PULSE) && !load_q;
  assign phaseloadreg = (state_q == ST_PULSE) && load_q;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed checks of command timing, position tracking, lock loss and reset.
module tb_ecp5pll_phase_ctrl;
  logic        clk_i = 1'b0;
  logic        reset, pll_locked_i, req_valid, req_dir, req_load;
  logic [1:0]  req_sel;
  logic [7:0]  req_steps;
  logic        req_ready, busy, done, err, locked_o;
  logic [31:0] pos_o;
  logic [1:0]  phasesel;
  logic        phasedir, phasestep, phaseloadreg;

  int vectors = 0, miscompares = 0;
  logic [31:0] t_stp, t_ldr, t_dn, t_er, t_bsy;
  logic        stable, never_both;

  ecp5pll_phase_ctrl dut (
    .clk_i(clk_i), .reset(reset), .pll_locked_i(pll_locked_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_steps(req_steps), .req_load(req_load),
    .busy(busy), .done(done), .err(err), .locked_o(locked_o), .pos_o(pos_o),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Issue one command from a negedge; trace bit k holds the value in cycle T+k
  // where T is the accepting edge. drop_k>0 drops the raw lock input in cycle T+drop_k.
  task automatic run_cmd(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                         input logic load, input int drop_k);
    t_stp = '0; t_ldr = '0; t_dn = '0; t_er = '0; t_bsy = '0;
    stable = 1'b1; never_both = 1'b1;
    req_sel = sel; req_dir = dir; req_steps = steps; req_load = load; req_valid = 1'b1;
    check("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk_i);
    for (int k = 1; k < 32; k++) begin
      @(negedge clk_i);
      if (k == 1) req_valid = 1'b0;
      if (k == drop_k) pll_locked_i = 1'b0;
      t_stp[k] = phasestep; t_ldr[k] = phaseloadreg; t_dn[k] = done;
      t_er[k]  = err;       t_bsy[k] = busy;
      if (busy && (phasesel !== sel || phasedir !== dir)) stable = 1'b0;
      if (phasestep && phaseloadreg) never_both = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; pll_locked_i = 1'b0; req_valid = 1'b0;
    req_sel = '0; req_dir = 1'b0; req_steps = '0; req_load = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", {busy, done, err, locked_o, req_ready, phasestep, phaseloadreg,
                            phasedir, phasesel}, 32'd0);
    check("reset_pos", pos_o, 32'd0);

    reset = 1'b0; pll_locked_i = 1'b1;
    @(negedge clk_i);
    check("locked_after_1_edge", 32'(locked_o), 32'd0);
    @(negedge clk_i);
    check("locked_after_2_edges", 32'(locked_o), 32'd1);
    check("ready_idle", 32'(req_ready), 32'd1);
    check("idle_pll_outputs", {phasestep, phaseloadreg, phasedir, phasesel}, 32'd0);

    // Two delay steps on CLKOS2
    run_cmd(2'd2, 1'b0, 8'd2, 1'b0, 0);
    check("s2_step", t_stp, mask(5, 8) | mask(13, 16));
    check("s2_done", t_dn, 32'h1 << 21);
    check("s2_busy", t_bsy, mask(1, 21));
    check("s2_ldr_err", t_ldr | t_er, 32'd0);
    check("s2_sel_dir_stable", 32'(stable), 32'd1);
    check("s2_pos", pos_o, 32'h0002_0000);

    // Advance from 0 wraps to 63, then delay wraps back to 0
    run_cmd(2'd1, 1'b1, 8'd1, 1'b0, 0);
    check("wrap_dn_step", t_stp, mask(5, 8));
    check("wrap_dn_done", t_dn, 32'h1 << 13);
    check("wrap_dn_pos", pos_o, 32'h0002_3F00);
    run_cmd(2'd1, 1'b0, 8'd1, 1'b0, 0);
    check("wrap_up_pos", pos_o, 32'h0002_0000);
    check("wrap_up_stable", 32'(stable), 32'd1);

    // Zero steps: no pulses, done straight after SETUP
    run_cmd(2'd0, 1'b0, 8'd0, 1'b0, 0);
    check("zero_pulses", t_stp | t_ldr, 32'd0);
    check("zero_done", t_dn, 32'h1 << 5);
    check("zero_pos", pos_o, 32'h0002_0000);

    // Load clears CLKOS2 with a single phaseloadreg pulse
    run_cmd(2'd2, 1'b0, 8'd7, 1'b1, 0);
    check("load_ldr", t_ldr, mask(5, 8));
    check("load_step", t_stp, 32'd0);
    check("load_done", t_dn, 32'h1 << 13);
    check("load_pos", pos_o, 32'h0000_0000);
    check("load_never_both", 32'(never_both), 32'd1);

    // Lock lost during the third of five pulses on CLKOS3
    run_cmd(2'd3, 1'b0, 8'd5, 1'b0, 21);
    check("abort_step", t_stp, mask(5, 8) | mask(13, 16) | mask(21, 23));
    check("abort_err", t_er, 32'h1 << 24);
    check("abort_done", t_dn, 32'd0);
    check("abort_busy", t_bsy, mask(1, 23));
    check("abort_pos", pos_o, 32'h0200_0000);

    // Held request must not be accepted while unlocked
    req_sel = 2'd0; req_dir = 1'b0; req_steps = 8'd3; req_load = 1'b0; req_valid = 1'b1;
    t_bsy = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      t_bsy[k] = busy | req_ready;
    end
    check("unlocked_no_accept", t_bsy, 32'd0);
    req_valid = 1'b0; pll_locked_i = 1'b1;
    @(negedge clk_i);
    check("relock_1_edge_ready", 32'(req_ready), 32'd0);
    @(negedge clk_i);
    check("relock_2_edges_ready", 32'(req_ready), 32'd1);

    // Reset in the middle of the second pulse
    req_valid = 1'b1;
    @(posedge clk_i);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk_i);
      if (k == 1) req_valid = 1'b0;
    end
    check("pre_reset_step", 32'(phasestep), 32'd1);
    check("pre_reset_pos", pos_o, 32'h0200_0001);
    reset = 1'b1;
    @(negedge clk_i);
    check("mid_reset_step", 32'(phasestep), 32'd0);
    check("mid_reset_pos", pos_o, 32'd0);
    check("mid_reset_busy_lock", {busy, locked_o}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
